// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus target: FSM encoding, register map constants
// and the byte-lane merge helper.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACK    = 3'd3,
        ST_IGNORE = 3'd4
    } state_e;

    localparam int          NUM_REGS         = 16;
    localparam int          NUM_RW_REGS      = NUM_REGS - 1;
    localparam logic [15:0] ID_VALUE_DEFAULT = 16'h5053;
    localparam logic [3:0]  ID_IDX           = 4'd15;
    localparam logic [2:0]  FC_CPU_SPACE     = 3'b111;

    // Replace only the byte lanes whose data strobe is asserted (active low).
    function automatic logic [15:0] byte_merge(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic        uds_n,
                                               input logic        lds_n);
        byte_merge = {(uds_n ? old_v[15:8] : new_v[15:8]),
                      (lds_n ? old_v[7:0]  : new_v[7:0])};
    endfunction

endpackage

// File: rtl/m68k_sync2.sv
// Two-flop synchronizer bank for asynchronous bus inputs sampled in the PI_CLK domain.
module m68k_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability filter: two back-to-back capture stages.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 bus target: 15 read/write word registers plus a read-only ID register,
// with programmable wait states counted on falling edges of the 68000 clock.
module m68k_bus_target
    import m68k_bus_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = 24'hDFF000,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic        PI_CLK,
    input  logic        M68K_RESET_n,
    input  logic        M68K_CLK,
    input  logic [22:0] M68K_A,
    input  logic [2:0]  M68K_FC,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    input  logic [15:0] M68K_D_IN,
    output logic [15:0] M68K_D_OUT,
    output logic        M68K_D_OE,
    output logic        DTACK_OE,
    output logic        BERR_OE,
    output logic        WR_STROBE,
    output logic [3:0]  WR_IDX
);

    logic [4:0] sync_s;
    logic       as_n_s, uds_n_s, lds_n_s, rw_s, c7m_s, c7m_fall_s, hit_s, wr_en_s;
    logic [3:0] dec_idx_s;
    logic [15:0] rd_data_s;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, idx_q, idx_d, wr_idx_q, wr_idx_d;
    logic        rw_q, rw_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
    logic [15:0] wdata_q, wdata_d, d_out_q, d_out_d;
    logic        dtack_q, dtack_d, berr_q, berr_d, d_oe_q, d_oe_d, wr_strobe_q, wr_strobe_d;
    logic        c7m_prev_q;
    logic [1:0]  warm_q;
    logic [15:0] regs_q [NUM_RW_REGS];

    m68k_sync2 #(.WIDTH(5)) u_sync (
        .clk_i   (PI_CLK),
        .rst_n_i (M68K_RESET_n),
        .d_i     ({M68K_CLK, M68K_RW, M68K_LDS_n, M68K_UDS_n, M68K_AS_n}),
        .q_o     (sync_s)
    );

    assign as_n_s     = sync_s[0];
    assign uds_n_s    = sync_s[1];
    assign lds_n_s    = sync_s[2];
    assign rw_s       = sync_s[3];
    assign c7m_s      = sync_s[4];
    assign c7m_fall_s = c7m_prev_q & ~c7m_s;

    assign dec_idx_s = M68K_A[3:0];
    assign hit_s     = (M68K_A[22:4] == BASE_ADDR[23:5]) && (M68K_FC != FC_CPU_SPACE);
    assign rd_data_s = (dec_idx_s == ID_IDX) ? ID_VALUE : regs_q[dec_idx_s];

    // Next-state and registered-output logic of the bus FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rw_d        = rw_q;
        uds_n_d     = uds_n_q;
        lds_n_d     = lds_n_q;
        wdata_d     = wdata_q;
        d_out_d     = d_out_q;
        dtack_d     = dtack_q;
        berr_d      = berr_q;
        d_oe_d      = d_oe_q;
        wr_idx_d    = wr_idx_q;
        wr_strobe_d = 1'b0;
        wr_en_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Synchronizer reset value reads as AS asserted; wait until it holds real samples.
                if (warm_q[1] && !as_n_s) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                end else if (!uds_n_s || !lds_n_s) begin
                    if (hit_s) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                        idx_d   = dec_idx_s;
                        rw_d    = rw_s;
                        uds_n_d = uds_n_s;
                        lds_n_d = lds_n_s;
                        wdata_d = M68K_D_IN;
                        d_oe_d  = rw_s;
                        if (rw_s) begin
                            d_out_d = rd_data_s;
                        end else begin
                            d_out_d = d_out_q;
                        end
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_WAIT: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                    d_oe_d  = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    if (rw_q) begin
                        dtack_d = 1'b1;
                    end else if (idx_q == ID_IDX) begin
                        berr_d = 1'b1;
                    end else begin
                        dtack_d     = 1'b1;
                        wr_en_s     = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_idx_d    = idx_q;
                    end
                end else if (c7m_fall_s) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ACK: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                    dtack_d = 1'b0;
                    berr_d  = 1'b0;
                    d_oe_d  = 1'b0;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_IGNORE: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_IGNORE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dtack_d = 1'b0;
                berr_d  = 1'b0;
                d_oe_d  = 1'b0;
            end
        endcase
    end

    // State, captured cycle attributes, outputs and register file.
    always_ff @(posedge PI_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= 4'd0;
            rw_q        <= 1'b1;
            uds_n_q     <= 1'b1;
            lds_n_q     <= 1'b1;
            wdata_q     <= 16'h0000;
            d_out_q     <= 16'h0000;
            dtack_q     <= 1'b0;
            berr_q      <= 1'b0;
            d_oe_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_idx_q    <= 4'd0;
            c7m_prev_q  <= 1'b0;
            warm_q      <= 2'b00;
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rw_q        <= rw_d;
            uds_n_q     <= uds_n_d;
            lds_n_q     <= lds_n_d;
            wdata_q     <= wdata_d;
            d_out_q     <= d_out_d;
            dtack_q     <= dtack_d;
            berr_q      <= berr_d;
            d_oe_q      <= d_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_idx_q    <= wr_idx_d;
            c7m_prev_q  <= c7m_s;
            warm_q      <= {warm_q[0], 1'b1};
            if (wr_en_s) begin
                regs_q[idx_q] <= byte_merge(regs_q[idx_q], wdata_q, uds_n_q, lds_n_q);
            end
        end
    end

    assign M68K_D_OUT = d_out_q;
    assign M68K_D_OE  = d_oe_q;
    assign DTACK_OE   = dtack_q;
    assign BERR_OE    = berr_q;
    assign WR_STROBE  = wr_strobe_q;
    assign WR_IDX     = wr_idx_q;

endmodule
